pcs_10g_block_lock: RTL and testbench

Clause 49.2.13.2.2 block-lock controller for the 10GBASE-R RX path. It inspects the 2-bit sync header of every 66-bit block from the gearbox and sequences bit-slips until 64 consecutive valid headers are seen. It then asserts `block_lock`, which gates the descrambler/64B/66B decoder block-valid. While locked it monitors invalid headers and drops lock and slips again when the error count is excessive.

---
 rtl/pcs_10g_block_lock.sv | 197 +++++++++++++++++++
 tb/tb_pcs_10g_block_lock.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_10g_block_lock.sv
// rtl/pcs_10g_block_lock.sv - 10GBASE-R receive block-lock controller
//
// Purpose:
//   Watches the 2-bit sync header of each 66-bit block delivered by the RX
//   gearbox and commands single-bit slips until SH_CNT_MAX consecutive valid
//   headers are seen. Once locked, it counts invalid headers per window and
//   drops lock (and slips again) when INVALID_MAX of them land in one window.
//
// Ports:
//   clk                 PCS RX block clock
//   rst                 asynchronous, active-high reset
//   rx_sh[1:0]          sync header of the current block (rx_block[65:64])
//   rx_sh_valid         rx_sh is valid this cycle
//   signal_ok           PMA signal detect (level)
//   slip_req            ask the gearbox to shift alignment by one bit, held until ack
//   slip_ack            gearbox slip done (single-cycle pulse)
//   block_lock          block lock achieved
//   rx_block_valid_out  rx_sh_valid & block_lock, combinational, for the decoder
//   slip_count[15:0]    slips issued since reset, saturating
//   lock_loss_count[15:0] falling edges of block_lock, saturating

module pcs_10g_block_lock #(
    parameter int SH_CNT_MAX   = 64,
    parameter int INVALID_MAX  = 16,
    parameter int SLIP_DISCARD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  rx_sh,
    input  logic        rx_sh_valid,
    input  logic        signal_ok,
    output logic        slip_req,
    input  logic        slip_ack,
    output logic        block_lock,
    output logic        rx_block_valid_out,
    output logic [15:0] slip_count,
    output logic [15:0] lock_loss_count
);

    localparam logic [1:0] ST_LOCK_INIT = 2'd0;
    localparam logic [1:0] ST_TEST_SH   = 2'd1;
    localparam logic [1:0] ST_SLIP      = 2'd2;
    localparam logic [1:0] ST_DISCARD   = 2'd3;

    localparam logic [6:0] SH_CNT_MAX_C   = 7'(SH_CNT_MAX);
    localparam logic [4:0] INVALID_MAX_C  = 5'(INVALID_MAX);
    localparam logic [3:0] SLIP_DISCARD_C = 4'(SLIP_DISCARD);

    logic [1:0]  state_q,           state_d;
    logic [6:0]  sh_cnt_q,          sh_cnt_d;
    logic [4:0]  sh_invalid_cnt_q,  sh_invalid_cnt_d;
    logic [3:0]  discard_cnt_q,     discard_cnt_d;
    logic        block_lock_q,      block_lock_d;
    logic        slip_req_q,        slip_req_d;
    logic [15:0] slip_count_q,      slip_count_d;
    logic [15:0] lock_loss_count_q, lock_loss_count_d;

    // Header evaluation helpers
    logic        sh_ok;
    logic [6:0]  sh_cnt_inc;
    logic [4:0]  sh_invalid_inc;
    logic        enter_slip;

    always_comb begin
        // 2'b01 and 2'b10 are the only legal sync headers
        sh_ok          = rx_sh[1] ^ rx_sh[0];
        sh_cnt_inc     = sh_cnt_q + 7'd1;
        sh_invalid_inc = sh_invalid_cnt_q + {4'd0, ~sh_ok};
    end

    always_comb begin
        state_d           = state_q;
        sh_cnt_d          = sh_cnt_q;
        sh_invalid_cnt_d  = sh_invalid_cnt_q;
        discard_cnt_d     = discard_cnt_q;
        block_lock_d      = block_lock_q;
        slip_req_d        = slip_req_q;
        slip_count_d      = slip_count_q;
        lock_loss_count_d = lock_loss_count_q;
        enter_slip        = 1'b0;

        if (!signal_ok) begin
            // Loss of signal overrides everything, including a pending slip:
            // the gearbox ack for a withdrawn request is never waited for.
            state_d          = ST_LOCK_INIT;
            block_lock_d     = 1'b0;
            slip_req_d       = 1'b0;
            sh_cnt_d         = 7'd0;
            sh_invalid_cnt_d = 5'd0;
            discard_cnt_d    = 4'd0;
        end else begin
            case (state_q)
                ST_LOCK_INIT: begin
                    block_lock_d     = 1'b0;
                    slip_req_d       = 1'b0;
                    sh_cnt_d         = 7'd0;
                    sh_invalid_cnt_d = 5'd0;
                    state_d          = ST_TEST_SH;
                end

                ST_TEST_SH: begin
                    if (rx_sh_valid) begin
                        sh_cnt_d         = sh_cnt_inc;
                        sh_invalid_cnt_d = sh_invalid_inc;
                        // Slip decisions are checked first so they win over
                        // an end-of-window on the same block.
                        if (!sh_ok && !block_lock_q) begin
                            enter_slip = 1'b1;
                        end else if (!sh_ok && (sh_invalid_inc == INVALID_MAX_C)) begin
                            block_lock_d = 1'b0;
                            enter_slip   = 1'b1;
                        end else if (sh_cnt_inc == SH_CNT_MAX_C) begin
                            if (sh_invalid_inc == 5'd0) begin
                                block_lock_d = 1'b1;
                            end
                            sh_cnt_d         = 7'd0;
                            sh_invalid_cnt_d = 5'd0;
                        end
                    end
                end

                ST_SLIP: begin
                    // Headers seen while the gearbox realigns are meaningless
                    if (slip_ack) begin
                        slip_req_d = 1'b0;
                        if (SLIP_DISCARD_C == 4'd0) begin
                            state_d = ST_TEST_SH;
                        end else begin
                            state_d       = ST_DISCARD;
                            discard_cnt_d = SLIP_DISCARD_C;
                        end
                    end
                end

                ST_DISCARD: begin
                    // Flush blocks still in flight from the old alignment
                    if (rx_sh_valid) begin
                        if (discard_cnt_q <= 4'd1) begin
                            discard_cnt_d = 4'd0;
                            state_d       = ST_TEST_SH;
                        end else begin
                            discard_cnt_d = discard_cnt_q - 4'd1;
                        end
                    end
                end

                default: begin
                    state_d = ST_LOCK_INIT;
                end
            endcase

            if (enter_slip) begin
                state_d          = ST_SLIP;
                slip_req_d       = 1'b1;
                sh_cnt_d         = 7'd0;
                sh_invalid_cnt_d = 5'd0;
                if (slip_count_q != 16'hFFFF) begin
                    slip_count_d = slip_count_q + 16'd1;
                end
            end
        end

        // Count every 1->0 of block_lock, whatever caused it
        if (block_lock_q && !block_lock_d && (lock_loss_count_q != 16'hFFFF)) begin
            lock_loss_count_d = lock_loss_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= ST_LOCK_INIT;
            sh_cnt_q          <= 7'd0;
            sh_invalid_cnt_q  <= 5'd0;
            discard_cnt_q     <= 4'd0;
            block_lock_q      <= 1'b0;
            slip_req_q        <= 1'b0;
            slip_count_q      <= 16'd0;
            lock_loss_count_q <= 16'd0;
        end else begin
            state_q           <= state_d;
            sh_cnt_q          <= sh_cnt_d;
            sh_invalid_cnt_q  <= sh_invalid_cnt_d;
            discard_cnt_q     <= discard_cnt_d;
            block_lock_q      <= block_lock_d;
            slip_req_q        <= slip_req_d;
            slip_count_q      <= slip_count_d;
            lock_loss_count_q <= lock_loss_count_d;
        end
    end

    assign slip_req           = slip_req_q;
    assign block_lock         = block_lock_q;
    assign slip_count         = slip_count_q;
    assign lock_loss_count    = lock_loss_count_q;
    assign rx_block_valid_out = rx_sh_valid & block_lock_q;

endmodule

// File: tb/tb_pcs_10g_block_lock.sv
// tb/tb_pcs_10g_block_lock.sv - directed self-checking bench for pcs_10g_block_lock

module tb_pcs_10g_block_lock;

    logic        clk;
    logic        rst;
    logic [1:0]  rx_sh;
    logic        rx_sh_valid;
    logic        signal_ok;
    logic        slip_req;
    logic        slip_ack;
    logic        block_lock;
    logic        rx_block_valid_out;
    logic [15:0] slip_count;
    logic [15:0] lock_loss_count;

    int n_cmp;
    int n_err;
    logic slip_seen;

    pcs_10g_block_lock #(
        .SH_CNT_MAX   (64),
        .INVALID_MAX  (16),
        .SLIP_DISCARD (2)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .rx_sh              (rx_sh),
        .rx_sh_valid        (rx_sh_valid),
        .signal_ok          (signal_ok),
        .slip_req           (slip_req),
        .slip_ack           (slip_ack),
        .block_lock         (block_lock),
        .rx_block_valid_out (rx_block_valid_out),
        .slip_count         (slip_count),
        .lock_loss_count    (lock_loss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One valid block; idle header afterwards is illegal so that any sampling
    // of rx_sh on non-valid cycles would be caught.
    task automatic send(input logic [1:0] sh);
        rx_sh       = sh;
        rx_sh_valid = 1'b1;
        tick();
        rx_sh_valid = 1'b0;
        rx_sh       = 2'b11;
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) begin
            send(2'b01);
            slip_seen = slip_seen | slip_req;
        end
    endtask

    task automatic pulse_ack();
        slip_ack = 1'b1;
        tick();
        slip_ack = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        slip_seen   = 1'b0;
        rst         = 1'b1;
        rx_sh       = 2'b11;
        rx_sh_valid = 1'b1;
        signal_ok   = 1'b0;
        slip_ack    = 1'b0;

        // Reset state
        #2;
        check("rst_slip_req", int'(slip_req), 0);
        check("rst_lock", int'(block_lock), 0);
        check("rst_rbv", int'(rx_block_valid_out), 0);
        check("rst_slip_cnt", int'(slip_count), 0);
        check("rst_loss_cnt", int'(lock_loss_count), 0);
        rx_sh_valid = 1'b0;
        tick();
        rst       = 1'b0;
        signal_ok = 1'b1;
        tick();

        // 1: 64 clean back-to-back blocks
        send_clean(63);
        check("t1_lock_b63", int'(block_lock), 0);
        send_clean(1);
        check("t1_lock_b64", int'(block_lock), 1);
        check("t1_no_slip", int'(slip_seen), 0);
        check("t1_slip_cnt", int'(slip_count), 0);

        // 2: unlocked, block 10 invalid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        send_clean(9);
        check("t2_pre_slip", int'(slip_req), 0);
        send(2'b11);
        check("t2_slip_req", int'(slip_req), 1);
        check("t2_slip_cnt", int'(slip_count), 1);
        send(2'b01);
        send(2'b01);
        check("t2_slip_held", int'(slip_req), 1);
        pulse_ack();
        check("t2_slip_drop", int'(slip_req), 0);
        send(2'b11);
        send(2'b11);
        check("t2_discard_ign", int'(slip_req), 0);
        send_clean(63);
        check("t2_lock_b63", int'(block_lock), 0);
        send_clean(1);
        check("t2_lock_b64", int'(block_lock), 1);
        check("t2_slip_cnt_end", int'(slip_count), 1);

        // 3: 15 invalid in one window keeps lock, 16 in next drops it
        for (int i = 0; i < 64; i++) begin
            send(((i % 4) == 0 && i < 60) ? 2'b11 : 2'b01);
        end
        check("t3_lock_15inv", int'(block_lock), 1);
        check("t3_no_slip", int'(slip_req), 0);
        for (int i = 0; i <= 30; i++) begin
            send(((i % 2) == 0) ? 2'b11 : 2'b01);
            if (i == 28) check("t3_lock_w2_15", int'(block_lock), 1);
        end
        check("t3_lock_lost", int'(block_lock), 0);
        check("t3_slip_req", int'(slip_req), 1);
        check("t3_loss_cnt", int'(lock_loss_count), 1);
        check("t3_slip_cnt", int'(slip_count), 2);

        // 4: 16th invalid on the 64th block of a window
        pulse_ack();
        send(2'b01);
        send(2'b01);
        send_clean(64);
        check("t4_relock", int'(block_lock), 1);
        for (int i = 1; i <= 64; i++) begin
            send((i <= 15 || i == 64) ? 2'b11 : 2'b01);
            if (i == 63) check("t4_lock_b63", int'(block_lock), 1);
        end
        check("t4_lock_lost", int'(block_lock), 0);
        check("t4_slip_req", int'(slip_req), 1);
        check("t4_loss_cnt", int'(lock_loss_count), 2);
        check("t4_slip_cnt", int'(slip_count), 3);

        // 5: signal_ok drop with slip pending, stray acks afterwards
        signal_ok = 1'b0;
        tick();
        check("t5_slip_withdrawn", int'(slip_req), 0);
        check("t5_lock", int'(block_lock), 0);
        signal_ok = 1'b1;
        slip_ack  = 1'b1;
        tick();
        rx_sh       = 2'b01;
        rx_sh_valid = 1'b1;
        tick();
        slip_ack    = 1'b0;
        rx_sh_valid = 1'b0;
        check("t5_stray_ack", int'(slip_req), 0);
        check("t5_slip_cnt", int'(slip_count), 3);
        send_clean(62);
        check("t5_lock_b63", int'(block_lock), 0);
        send_clean(1);
        check("t5_relock", int'(block_lock), 1);
        check("t5_loss_cnt", int'(lock_loss_count), 2);
        signal_ok = 1'b0;
        tick();
        check("t5_sig_lock", int'(block_lock), 0);
        check("t5_sig_loss_cnt", int'(lock_loss_count), 3);
        signal_ok = 1'b1;
        tick();

        // 6: gapped valid, combinational valid out, async reset
        for (int i = 1; i <= 64; i++) begin
            send(2'b01);
            if (i == 63) check("t6_lock_b63", int'(block_lock), 0);
            if (i < 64) begin
                tick();
                tick();
            end
        end
        check("t6_lock_b64", int'(block_lock), 1);
        rx_sh_valid = 1'b1;
        #1;
        check("t6_rbv_hi", int'(rx_block_valid_out), 1);
        rx_sh_valid = 1'b0;
        #1;
        check("t6_rbv_lo", int'(rx_block_valid_out), 0);
        tick();
        send_clean(10);
        #1;
        rst         = 1'b1;
        rx_sh_valid = 1'b1;
        #1;
        check("t6_arst_lock", int'(block_lock), 0);
        check("t6_arst_slip_req", int'(slip_req), 0);
        check("t6_arst_slip_cnt", int'(slip_count), 0);
        check("t6_arst_loss_cnt", int'(lock_loss_count), 0);
        check("t6_arst_rbv", int'(rx_block_valid_out), 0);
        rx_sh_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
